// File: rtl/mdu_hilo.sv
// Iterative 32-step multiply/divide unit holding the architectural HI/LO pair.
// Signed operations run on magnitudes and the signs are fixed up in the FINISH cycle.
module mdu_hilo (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {StIdle, StCompute, StFinish} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        div_q, div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        finish_wr;
  logic        mt_ok;
  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_step;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign accept    = (state_q == StIdle) && start_i && !flush_i;
  assign finish_wr = (state_q == StFinish) && !flush_i;
  assign signed_op = ~op_i[0];

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StCompute;
      end
      StCompute: begin
        if (flush_i)              state_d = StIdle;
        else if (cnt_q == 5'd31)  state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    busy_d = (state_d != StIdle);
    done_d = finish_wr;
    mt_ok  = (state_q == StIdle) && !start_i;
  end

  // Datapath: the accumulator starts as {0, |a|}; multiply shifts right, divide shifts left.
  always_comb begin
    a_mag     = (signed_op && a_i[31]) ? -a_i : a_i;
    b_mag     = (signed_op && b_i[31]) ? -b_i : b_i;

    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_step  = {mul_sum, acc_q[31:1]};

    div_shift = acc_q[63:31];
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_sub   = div_shift[31:0] - opnd_q;
    div_step  = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                       : {div_shift[31:0], acc_q[30:0], 1'b0};

    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = (neg_q && !dz_q) ? -acc_q[31:0] : acc_q[31:0];
    rem_fix   = rneg_q ? -acc_q[63:32] : acc_q[63:32];
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (accept) begin
      cnt_d  = 5'd0;
      acc_d  = {32'd0, a_mag};
      opnd_d = b_mag;
      div_d  = op_i[1];
      neg_d  = signed_op && (a_i[31] ^ b_i[31]);
      rneg_d = signed_op && op_i[1] && a_i[31];
      dz_d   = op_i[1] && (b_i == 32'd0);
    end else if (state_q == StCompute) begin
      cnt_d = cnt_q + 5'd1;
      acc_d = div_q ? div_step : mul_step;
    end

    if (finish_wr) begin
      if (div_q) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        hi_d = prod_fix[63:32];
        lo_d = prod_fix[31:0];
      end
    end else if (mt_ok) begin
      if (hi_we_i) hi_d = wdata_i;
      if (lo_we_i) lo_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= 5'd0;
      acc_q  <= 64'd0;
      opnd_q <= 32'd0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: a cycle-level arithmetic model is compared every cycle,
// and literal HI/LO/latency values are checked after each directed operation.
module tb_mdu_hilo;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mdu_hilo dut (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .flush_i (flush),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .wdata_i (wdata),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      MULT:  begin q = sx * sy; p = q; end
      MULTU: p = ux * uy;
      DIV: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else p = {(x % y), (x / y)};
      end
    endcase
    return p;
  endfunction

  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  // Timing model: result appears 34 cycles after acceptance unless flushed.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_res  <= 64'd0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (flush) begin
          m_busy <= 1'b0;
        end else if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start && !flush) begin
        m_res  <= model_res(op, a, b);
        m_left <= 33;
        m_busy <= 1'b1;
      end else if (!start) begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
      end
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t busy=%b/%b done=%b/%b hi=%h/%h lo=%h/%h (got/expected)",
               $time, busy, m_busy, done, m_done, hi, m_hi, lo, m_lo);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Leaves the bench in cycle T+1; operands are scrambled to show they were captured.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op    = 2'($urandom_range(3));
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string nm, input int n0, input logic [31:0] eh,
                           input logic [31:0] el);
    int n;
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd34);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    flush = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    start_op(DIVU, 32'd100, 32'd7);
    wait_done("divu 100/7", 1, 32'd2, 32'd14);
    tick();
    start_op(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div -7/2", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tick();
    start_op(MULT, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult -1*2", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    tick();
    start_op(MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu", 1, 32'd1, 32'hFFFF_FFFE);
    tick();
    start_op(DIVU, 32'd5, 32'd0);
    wait_done("divu by 0", 1, 32'd5, 32'hFFFF_FFFF);
    tick();
    start_op(DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done("div -7 by 0", 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    tick();
    start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div min/-1", 1, 32'd0, 32'h8000_0000);
    tick();
    start_op(MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult min*min", 1, 32'h4000_0000, 32'd0);
    tick();

    // MTHI then a flushed divide leaves HI untouched
    hi_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    tick();
    hi_we = 1'b0;
    chk("mthi", hi, 32'hDEAD_BEEF);
    start_op(DIVU, 32'd9, 32'd2);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush hi", hi, 32'hDEAD_BEEF);
    repeat (30) tick();
    chk("flush no done", {31'd0, done}, 32'd0);

    // start held high while busy
    start = 1'b1;
    op    = DIVU;
    a     = 32'd100;
    b     = 32'd7;
    tick();
    a = 32'd1;
    b = 32'd1;
    op = MULTU;
    repeat (15) tick();
    start = 1'b0;
    wait_done("start held", 16, 32'd2, 32'd14);
    tick();

    // back-to-back: second start in the done cycle
    start_op(MULTU, 32'd3, 32'd4);
    wait_done("b2b multu", 1, 32'd0, 32'd12);
    start_op(DIVU, 32'd9, 32'd2);
    wait_done("b2b divu", 1, 32'd1, 32'd4);
    tick();

    // MTLO together with start is dropped
    lo_we = 1'b1;
    wdata = 32'h1234_5678;
    start_op(DIVU, 32'd100, 32'd7);
    chk("mtlo dropped", lo, 32'd4);
    wait_done("divu after mtlo", 1, 32'd2, 32'd14);
    tick();

    // asynchronous reset mid-compute
    start_op(MULT, 32'd5, 32'd6);
    repeat (8) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("areset busy", {31'd0, busy}, 32'd0);
    chk("areset done", {31'd0, done}, 32'd0);
    chk("areset hi", hi, 32'd0);
    chk("areset lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    repeat (40) tick();
    chk("after reset no done", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with the architectural HI/LO register pair, sitting beside the single-cycle ALU in the execute stage. It covers MULT/MULTU/DIV/DIVU, which the ALU does not implement, and holds the HI/LO state read by MFHI/MFLO and written by MTHI/MTLO. It takes one operation at a time, runs a shared 32-step shift datapath, and signals completion with a one-cycle pulse so the issue logic can stall on `busy`.

## Interface
- No parameters. Iteration count is fixed at 32.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to begin an operation; sampled only in IDLE.
- `op`  in  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `a`  in  32  multiplicand / dividend (rs).
- `b`  in  32  multiplier / divisor (rt).
- `flush`  in  1  abort in-flight operation (exception/branch flush).
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write enables.
- `wdata`  in  32  MTHI/MTLO write data.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse: HI/LO now hold the new result.
- `hi`, `lo`  out  32 each  current HI/LO register values.

## Operation
- States: IDLE, COMPUTE, FINISH.
- IDLE with `start`=1 and `flush`=0:
  - latch |a| and |b|; signed ops use two's-complement magnitude, unsigned ops use raw values;
  - latch the result signs: quotient/product negative iff a[31]^b[31] (signed ops only); remainder sign = a[31] (DIV only);
  - latch a divide-by-zero flag (b==0, DIV/DIVU);
  - clear the step counter; go to COMPUTE.
- COMPUTE: one step per cycle, counter 0..31; after step 31, go to FINISH.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring radix-2, 33-bit partial remainder, one quotient bit per step.
- FINISH: apply sign fixup (negate 64-bit product, or quotient/remainder separately), write HI/LO, pulse `done`, return to IDLE.
- Result mapping:
  - multiply: HI = product[63:32], LO = product[31:0];
  - divide: LO = quotient, HI = remainder.
- Divide by zero (either signedness): LO = 32'hFFFF_FFFF, HI = a as presented. No exception.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0. This falls out of the magnitude datapath; no special case.
- MULT −2^31 × −2^31: HI = 32'h4000_0000, LO = 0.
- MTHI/MTLO:
  - `hi_we`/`lo_we` update HI/LO with `wdata` only when state is IDLE and `start`=0;
  - when `start`=1 in the same cycle, or while busy, the writes are dropped (issue logic must not send them).
- `flush`:
  - any state → IDLE at the next edge; no `done`; HI/LO keep their pre-operation values;
  - `flush` with `start` in IDLE: start is ignored.
- `start` while not in IDLE is ignored. Operands are captured at acceptance, so `a`/`b`/`op` may change afterwards.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0. Reset asserted mid-operation aborts immediately.
- Latency, with `start` sampled at the edge ending cycle T:
  - `busy`=1 in cycles T+1..T+33 (32 COMPUTE plus 1 FINISH);
  - `done`=1 and new HI/LO visible in cycle T+34;
  - `busy`=0 in that cycle.
- `busy` is a registered decode of state ≠ IDLE. `done` is registered.
- Back-to-back: a new `start` is accepted in the `done` cycle. Its `done` follows 34 cycles later.
- `flush` in cycle T+33 (FINISH) still suppresses the write and `done`.
- HI/LO outputs are direct register outputs. An MTHI write in cycle T is visible in cycle T+1.

## Test plan
- Reset, then idle: `hi`=`lo`=0, `busy`=`done`=0. Assert reset during COMPUTE → all outputs return to 0 asynchronously.
- DIVU a=100, b=7 → `done` exactly 34 cycles after start, LO=14, HI=2. DIV a=−7 (32'hFFFF_FFF9), b=2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- MULT a=32'hFFFF_FFFF, b=2 → HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFE. MULTU with the same operands → HI=1, LO=32'hFFFF_FFFE.
- Corners:
  - DIVU a=5, b=0 → LO=32'hFFFF_FFFF, HI=5;
  - DIV 32'h8000_0000 / −1 → LO=32'h8000_0000, HI=0;
  - MULT 32'h8000_0000 × 32'h8000_0000 → HI=32'h4000_0000, LO=0.
- Flush and start rules:
  - MTHI 32'hDEAD_BEEF, then start DIVU 9/2, flush at cycle T+10 → no `done`, HI stays 32'hDEAD_BEEF, `busy` drops in cycle T+11;
  - `start` held high during `busy` has no effect.
- Back-to-back and write conflicts:
  - MULTU 3×4, then DIVU 9/2 started in the `done` cycle → first HI/LO = 0/12, second = 1/4, second `done` 34 cycles after the first;
  - MTLO in the same cycle as `start` → write dropped.
